// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU sequencing controller.
package alu_arbiter_pkg;

  // Controller phases: waiting, ALU settling, response pending.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Number of requesters sharing the ALU.
  localparam int NUM_REQ = 2;

  // Bit positions inside the 7-bit flag word.
  localparam int FLAG_CARRY    = 0;
  localparam int FLAG_ZERO     = 1;
  localparam int FLAG_NEGATIVE = 2;
  localparam int FLAG_OVERFLOW = 3;
  localparam int FLAG_EQUAL    = 4;
  localparam int FLAG_LESS     = 5;
  localparam int FLAG_GREAT    = 6;
  localparam int FLAG_W        = 7;

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Two-input round-robin picker. A lone requester always wins; on a tie the
// requester named by ptr wins. The pointer register lives in the parent.
module rr_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               ptr,
  output logic [NUM_REQ-1:0] grant
);

  // One-hot grant selection.
  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: round-robin grant,
// registered ALU operands, one settling cycle, then a held response.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic [NUM_REQ-1:0]            ReqValid,
  output logic [NUM_REQ-1:0]            ReqReady,
  input  logic [NUM_REQ-1:0][WIDTH-1:0] ReqA,
  input  logic [NUM_REQ-1:0][WIDTH-1:0] ReqB,
  input  logic [NUM_REQ-1:0][4:0]       ReqOp,
  output logic [NUM_REQ-1:0]            RspValid,
  input  logic [NUM_REQ-1:0]            RspReady,
  output logic [WIDTH-1:0]              RspResult,
  output logic [FLAG_W-1:0]             RspFlags,
  output logic [WIDTH-1:0]              AluA,
  output logic [WIDTH-1:0]              AluB,
  output logic [4:0]                    AluOpcode,
  input  logic [WIDTH-1:0]              AluResult,
  input  logic [FLAG_W-1:0]             AluFlags
);

  state_t               state_reg, state_next;
  logic                 ptr_reg;
  logic                 owner_reg;
  logic [NUM_REQ-1:0]   grant;
  logic                 grant_idx;
  logic                 accept;
  logic                 rsp_done;

  rr_arbiter u_rr (
    .req   (ReqValid),
    .ptr   (ptr_reg),
    .grant (grant)
  );

  // Grant is one-hot, so bit 1 alone identifies the winner.
  assign grant_idx = grant[1];

  // Ready is offered only while idle and never during reset.
  assign ReqReady = ((state_reg == IDLE) && !Reset) ? grant : '0;
  assign accept   = |(ReqValid & ReqReady);
  assign rsp_done = (state_reg == RESP) && RspReady[owner_reg];

  // Only the owner's response valid is raised; the other bit stays low.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rsp_valid
      assign RspValid[gi] = (state_reg == RESP) && (owner_reg == 1'(gi));
    end
  endgenerate

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic: accept -> one settling cycle -> wait for owner's ready.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Owner is captured on accept; pointer moves past the owner on completion.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ptr_reg   <= 1'b0;
      owner_reg <= 1'b0;
    end else begin
      if (accept)   owner_reg <= grant_idx;
      if (rsp_done) ptr_reg   <= ~owner_reg;
    end
  end

  // ALU operands latch on accept; result and flags latch leaving EXEC.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      AluA      <= '0;
      AluB      <= '0;
      AluOpcode <= '0;
      RspResult <= '0;
      RspFlags  <= '0;
    end else begin
      if (accept) begin
        AluA      <= ReqA[grant_idx];
        AluB      <= ReqB[grant_idx];
        AluOpcode <= ReqOp[grant_idx];
      end
      if (state_reg == EXEC) begin
        RspResult <= AluResult;
        RspFlags  <= AluFlags;
      end
    end
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencing controller that shares one combinational ALU between two requesters. Each requester submits an operand pair and a 5-bit opcode over a valid/ready handshake. The block grants one requester using round-robin priority, registers the operands onto the ALU inputs, and captures the result and flags. It then returns them on a per-requester response handshake. It sits between the ALU instance and any bus masters or test-pattern sources in the FPGA top level.

## Interface
Parameters:
- WIDTH, 8, operand/result width; must match the attached ALU.

Ports:
- Clock  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- ReqValid  in  [1:0]  per-requester request valid.
- ReqReady  out  [1:0]  per-requester request accept; at most one bit set.
- ReqA  in  [1:0][WIDTH-1:0]  operand A per requester.
- ReqB  in  [1:0][WIDTH-1:0]  operand B per requester.
- ReqOp  in  [1:0][4:0]  opcode per requester.
- RspValid  out  [1:0]  response valid; at most one bit set, only the owner's bit.
- RspReady  in  [1:0]  per-requester response accept.
- RspResult  out  WIDTH  captured ALU result, shared by both requesters.
- RspFlags  out  7  captured flags {Great, Less, Equal, Overflow, Negative, Zero, CarryOut}, bit 0 = CarryOut.
- AluA, AluB  out  WIDTH  registered operands driven to the ALU.
- AluOpcode  out  5  registered opcode driven to the ALU.
- AluResult  in  WIDTH  ALU result.
- AluFlags  in  7  ALU flags, same packing as RspFlags.

## Operation
- FSM states:
  - IDLE: waiting for a request.
  - EXEC: ALU inputs stable, ALU settling.
  - RESP: response pending.
- Priority pointer: 1 bit; it names the requester preferred on a tie. Reset value is 0.
- Grant rule:
  - If exactly one ReqValid bit is set, that requester is granted regardless of the pointer.
  - If both bits are set, the pointer's requester is granted.
- ReqReady[i] = (state==IDLE) && grant[i] && !Reset. This is combinational from ReqValid.
- On a request handshake (ReqValid[i] && ReqReady[i]):
  - ReqA[i], ReqB[i] and ReqOp[i] are latched into AluA, AluB and AluOpcode.
  - Owner is latched as i; state goes to EXEC.
- EXEC to RESP is unconditional after one cycle. AluResult and AluFlags are captured into RspResult and RspFlags on that edge.
- RESP:
  - RspValid[owner]=1 until RspReady[owner]=1.
  - On that handshake, state goes to IDLE and the pointer is set to !owner.
  - RspReady on the non-owner bit is ignored.
- AluA, AluB and AluOpcode hold their values until the next request handshake.
- RspResult and RspFlags hold their values until the next EXEC capture.
- Opcode values 0–31 are passed through unmodified; the ALU alone defines their semantics.
- Only one operation is outstanding at a time. There is no queueing.

## Timing
- Reset values (asynchronous):
  - state=IDLE, pointer=0, owner=0.
  - AluA=0, AluB=0, AluOpcode=0.
  - RspValid=0, RspResult=0, RspFlags=0.
  - ReqReady=0 while Reset is high.
- Request handshake in cycle T:
  - T+1: EXEC.
  - T+2: RspValid[owner] high, with result valid in the same cycle.
- Latency is 2 cycles from accept to response valid.
- Minimum issue interval is 3 cycles: accept, EXEC, RESP with RspReady already high. The next accept is possible in the cycle after the response handshake.
- A request held during EXEC or RESP sees ReqReady=0 and is not lost. It is granted in IDLE per the pointer.
- Both requesters streaming continuously are served alternately: 0,1,0,1 after reset.
- A requester must hold its valid, operands and opcode until ready. Changes after the handshake are ignored.
- Reset asserted in EXEC or RESP aborts the operation: no response is issued and the pointer returns to 0.

## Structure
- Package alu_arbiter_pkg holds:
  - The state enum (IDLE, EXEC, RESP).
  - The flag bit-index constants (FLAG_CARRY=0 … FLAG_GREAT=6).
  - NUM_REQ=2.
- Sub-module rr_arbiter: a 2-input round-robin picker.
  - Inputs: request vector, pointer.
  - Output: one-hot grant.
  - Purely combinational; the pointer register lives in alu_arbiter.

## Test plan
- Reset, then requester 0 submits A=42, B=23, op=0:
  - ReqReady[0] is high in the same cycle.
  - RspValid[0] rises exactly 2 cycles later.
  - RspResult and RspFlags equal the golden ALU model output for (42, 23, 0).
- Both valid in the same cycle after reset (req0: 42,23,op 1; req1: 255,1,op 0):
  - Order is req0 first, then req1.
  - The pointer then prefers 0 again, and both keep alternating on continued traffic.
- Response backpressure: RspReady[0] held low for 5 cycles:
  - RspValid[0], RspResult and RspFlags stay stable.
  - ReqReady stays 0 for requester 1, which has a pending request.
  - Requester 1 is accepted in the cycle after the response handshake.
- Opcode sweep 0–31 with A=42, B=23 from requester 1 only:
  - Every response matches the model.
  - RspValid[0] is never set.
- Reset pulsed during EXEC:
  - All outputs return to reset values.
  - No RspValid is ever raised for the aborted operation.
  - The next request from requester 0 completes normally.
- Non-owner RspReady[1]=1 during requester 0's RESP has no effect; the state stays RESP.
